uart_cmd_parser: RTL and testbench

Parametrised packet parser between the UART receive byte stream and the ALU/echo paths. It accepts framed packets (opcode, reserved, 16-bit length, payload) over a valid/ready byte interface. Arithmetic payloads are assembled into a vector of up to `MAX_OPERANDS` operands of `OPERAND_W` bits and issued as one command. ECHO payloads stream straight through to the transmit side. Beyond the first-generation FSM, it adds configurable operand width and count, length validation, draining of malformed packets, and error reporting.

---
 rtl/uart_cmd_parser.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// Packet parser between the UART receive byte stream and the ALU/echo paths.
// Frames: opcode, reserved, 16-bit total length, payload (operands or echo bytes).

package config_pkg;
    localparam logic [7:0] OP_ECHO = 8'h01;
    localparam logic [7:0] OP_ADD  = 8'h02;
    localparam logic [7:0] OP_MUL  = 8'h03;
    localparam logic [7:0] OP_DIV  = 8'h04;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_BAD_OP    = 2'd1,
        ERR_LEN_SHORT = 2'd2,
        ERR_BAD_LEN   = 2'd3
    } err_code_e;
endpackage

module uart_cmd_parser
    import config_pkg::*;
#(
    parameter int OPERAND_W    = 32,
    parameter int MAX_OPERANDS = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [7:0]                             in_data_i,
    input  logic                                   in_valid_i,
    output logic                                   in_ready_o,
    output logic [7:0]                             echo_data_o,
    output logic                                   echo_valid_o,
    input  logic                                   echo_ready_i,
    output logic                                   cmd_valid_o,
    input  logic                                   cmd_ready_i,
    output logic [7:0]                             cmd_opcode_o,
    output logic [$clog2(MAX_OPERANDS+1)-1:0]      cmd_count_o,
    output logic [MAX_OPERANDS*OPERAND_W-1:0]      cmd_operands_o,
    output logic                                   err_o,
    output logic [1:0]                             err_code_o
);

    localparam int          BYTES      = OPERAND_W / 8;
    localparam int          CNT_W      = $clog2(MAX_OPERANDS + 1);
    localparam int          VEC_W      = MAX_OPERANDS * OPERAND_W;
    localparam int          SLOT_BYTES = MAX_OPERANDS * BYTES;
    localparam logic [15:0] BYTES_L    = 16'(BYTES);
    localparam logic [15:0] MAX_OPS_L  = 16'(MAX_OPERANDS);

    typedef enum logic [2:0] {
        S_OPCODE,
        S_RESERVED,
        S_LEN_LO,
        S_LEN_HI,
        S_OPERAND,
        S_ISSUE,
        S_ECHO,
        S_DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic              alive_q;
    logic [7:0]        opcode_q, opcode_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       plen_q, plen_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [VEC_W-1:0]  operands_q, operands_d;
    logic              err_q, err_d;
    err_code_e         err_code_q, err_code_d;

    logic              accept;
    logic [15:0]       len_w;
    logic [15:0]       plen_w;
    logic [15:0]       nops_w;
    logic [15:0]       rem_w;
    logic              last_w;

    function automatic logic is_known(input logic [7:0] op);
        return op inside {OP_ECHO, OP_ADD, OP_MUL, OP_DIV};
    endfunction

    assign accept = in_valid_i && in_ready_o;
    assign len_w  = {in_data_i, len_lo_q};
    assign plen_w = len_w - 16'd4;
    assign nops_w = plen_w / BYTES_L;
    assign rem_w  = plen_w % BYTES_L;
    assign last_w = (cnt_q == plen_q - 16'd1);

    // State and datapath registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: the operand slots are reset too, because the reset state of every
    // output, including unused operand slots, must be observably zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_OPCODE;
            alive_q    <= 1'b0;
            opcode_q   <= '0;
            len_lo_q   <= '0;
            plen_q     <= '0;
            cnt_q      <= '0;
            count_q    <= '0;
            operands_q <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            alive_q    <= 1'b1;
            opcode_q   <= opcode_d;
            len_lo_q   <= len_lo_d;
            plen_q     <= plen_d;
            cnt_q      <= cnt_d;
            count_q    <= count_d;
            operands_q <= operands_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // Next-state and datapath update.
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        len_lo_d   = len_lo_q;
        plen_d     = plen_q;
        cnt_d      = cnt_q;
        count_d    = count_q;
        operands_d = operands_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;

        case (state_q)
            S_OPCODE: begin
                if (accept) begin
                    if (is_known(in_data_i)) begin
                        opcode_d = in_data_i;
                        state_d  = S_RESERVED;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_BAD_OP;
                    end
                end
            end
            S_RESERVED: begin
                if (accept) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_lo_d = in_data_i;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    plen_d = plen_w;
                    cnt_d  = '0;
                    if (len_w < 16'd4) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_LEN_SHORT;
                        state_d    = S_OPCODE;
                    end else if (opcode_q == OP_ECHO) begin
                        state_d = (plen_w == 16'd0) ? S_OPCODE : S_ECHO;
                    end else if (rem_w != 16'd0 || nops_w < 16'd2 || nops_w > MAX_OPS_L) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_BAD_LEN;
                        state_d    = (plen_w == 16'd0) ? S_OPCODE : S_DRAIN;
                    end else begin
                        count_d = nops_w[CNT_W-1:0];
                        state_d = S_OPERAND;
                    end
                end
            end
            S_OPERAND: begin
                if (accept) begin
                    // Little-endian operands packed from slot 0 upward means
                    // payload byte k lands at bit k*8 of the flat vector.
                    for (int i = 0; i < SLOT_BYTES; i++) begin
                        if (cnt_q == 16'(i)) operands_d[i*8 +: 8] = in_data_i;
                    end
                    cnt_d = cnt_q + 16'd1;
                    if (last_w) begin
                        cnt_d   = '0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (cmd_ready_i) begin
                    operands_d = '0;
                    state_d    = S_OPCODE;
                end
            end
            S_ECHO, S_DRAIN: begin
                if (accept) begin
                    cnt_d = cnt_q + 16'd1;
                    if (last_w) begin
                        cnt_d   = '0;
                        state_d = S_OPCODE;
                    end
                end
            end
            default: state_d = S_OPCODE;
        endcase
    end

    // Handshake outputs; the echo path is a pure combinational passthrough.
    always_comb begin
        in_ready_o   = 1'b0;
        echo_valid_o = 1'b0;
        echo_data_o  = '0;
        cmd_valid_o  = 1'b0;

        case (state_q)
            S_ECHO: begin
                in_ready_o   = echo_ready_i;
                echo_valid_o = in_valid_i;
                echo_data_o  = in_data_i;
            end
            S_ISSUE: begin
                cmd_valid_o = 1'b1;
            end
            default: begin
                in_ready_o = alive_q;
            end
        endcase
    end

    assign cmd_opcode_o   = opcode_q;
    assign cmd_count_o    = count_q;
    assign cmd_operands_o = operands_q;
    assign err_o          = err_q;
    assign err_code_o     = err_code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomised bench for uart_cmd_parser: a packet-level model predicts commands,
// echo bytes and error codes; one compare process checks the DUT every cycle.
`timescale 1ns/1ps

module tb_uart_cmd_parser;
    import config_pkg::*;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int B  = W / 8;
    localparam int CW = $clog2(N + 1);
    localparam int VW = N * W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    in_data_i = '0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [7:0]    echo_data_o;
    logic          echo_valid_o;
    logic          echo_ready_i = 1'b0;
    logic          cmd_valid_o;
    logic          cmd_ready_i = 1'b0;
    logic [7:0]    cmd_opcode_o;
    logic [CW-1:0] cmd_count_o;
    logic [VW-1:0] cmd_operands_o;
    logic          err_o;
    logic [1:0]    err_code_o;

    uart_cmd_parser #(.OPERAND_W(W), .MAX_OPERANDS(N)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_data_i      (in_data_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .echo_data_o    (echo_data_o),
        .echo_valid_o   (echo_valid_o),
        .echo_ready_i   (echo_ready_i),
        .cmd_valid_o    (cmd_valid_o),
        .cmd_ready_i    (cmd_ready_i),
        .cmd_opcode_o   (cmd_opcode_o),
        .cmd_count_o    (cmd_count_o),
        .cmd_operands_o (cmd_operands_o),
        .err_o          (err_o),
        .err_code_o     (err_code_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]    op;
        logic [CW-1:0] cnt;
        logic [VW-1:0] ops;
    } cmd_t;

    cmd_t       exp_cmd[$];
    logic [7:0] exp_echo[$];
    logic [1:0] exp_err[$];

    int   n_checks = 0;
    int   n_errors = 0;
    bit   bg_rand = 1'b0;
    logic cmd_force = 1'b1;
    logic echo_force = 1'b1;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [VW-1:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: unexpected output 0x%0h with nothing predicted", name, act);
    endtask

    function automatic bit known(input logic [7:0] op);
        return op inside {OP_ECHO, OP_ADD, OP_MUL, OP_DIV};
    endfunction

    // Packet-level reference: what a whole packet must produce.
    task automatic model_packet(input logic [7:0] op, input int len, input logic [7:0] pay[$]);
        int         p;
        cmd_t       c;
        logic [W-1:0] val;
        if (!known(op)) begin
            exp_err.push_back(2'd1);
            return;
        end
        if (len < 4) begin
            exp_err.push_back(2'd2);
            return;
        end
        p = len - 4;
        if (op == OP_ECHO) begin
            foreach (pay[i]) exp_echo.push_back(pay[i]);
            return;
        end
        if (p % B != 0 || p / B < 2 || p / B > N) begin
            exp_err.push_back(2'd3);
            return;
        end
        c.op  = op;
        c.cnt = CW'(p / B);
        c.ops = '0;
        for (int o = 0; o < p / B; o++) begin
            val = '0;
            for (int j = B - 1; j >= 0; j--) val = val * 256 + W'(pay[o*B + j]);
            c.ops[o*W +: W] = val;
        end
        exp_cmd.push_back(c);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int waited = 0;
        if (gaps) begin
            while ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        in_valid_i = 1'b1;
        in_data_i  = b;
        forever begin
            #1;
            if (in_ready_o) break;
            @(negedge clk);
            waited++;
            if (waited > 1000) begin
                $display("FAIL send_timeout: byte 0x%0h not accepted within 1000 cycles", b);
                $fatal(1, "input stalled");
            end
        end
        @(negedge clk);
        in_valid_i = 1'b0;
    endtask

    task automatic send_packet(input logic [7:0] op, input int len, input logic [7:0] pay[$], input bit gaps);
        logic [15:0] l16;
        l16 = 16'(len);
        model_packet(op, len, pay);
        send_byte(op, gaps);
        if (!known(op)) return;
        send_byte(8'($urandom), gaps);
        send_byte(l16[7:0], gaps);
        send_byte(l16[15:8], gaps);
        foreach (pay[i]) send_byte(pay[i], gaps);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},   VW'(in_ready_o),     '0);
        check({tag, "_echo_valid"}, VW'(echo_valid_o),   '0);
        check({tag, "_echo_data"},  VW'(echo_data_o),    '0);
        check({tag, "_cmd_valid"},  VW'(cmd_valid_o),    '0);
        check({tag, "_opcode"},     VW'(cmd_opcode_o),   '0);
        check({tag, "_count"},      VW'(cmd_count_o),    '0);
        check({tag, "_operands"},   cmd_operands_o,      '0);
        check({tag, "_err"},        VW'(err_o),          '0);
        check({tag, "_err_code"},   VW'(err_code_o),     '0);
    endtask

    // Ready drivers, updated just after each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            #0.2;
            if (bg_rand) begin
                cmd_ready_i  = 1'($urandom_range(0, 1));
                echo_ready_i = 1'($urandom_range(0, 1));
            end else begin
                cmd_ready_i  = cmd_force;
                echo_ready_i = echo_force;
            end
        end
    end

    // Compare process: every cycle, against the model queues.
    initial begin : cmp_proc
        bit            hold;
        logic [7:0]    h_op;
        logic [CW-1:0] h_cnt;
        logic [VW-1:0] h_ops;
        cmd_t          c;
        logic [7:0]    e;
        logic [1:0]    ec;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (cmd_valid_o) begin
                    check("issue_in_ready", VW'(in_ready_o), '0);
                    if (hold) begin
                        check("hold_opcode",   VW'(cmd_opcode_o), VW'(h_op));
                        check("hold_count",    VW'(cmd_count_o),  VW'(h_cnt));
                        check("hold_operands", cmd_operands_o,    h_ops);
                    end
                    if (cmd_ready_i) begin
                        if (exp_cmd.size() == 0) begin
                            unexpected("cmd_unexpected", VW'(cmd_opcode_o));
                        end else begin
                            c = exp_cmd.pop_front();
                            check("cmd_opcode",   VW'(cmd_opcode_o), VW'(c.op));
                            check("cmd_count",    VW'(cmd_count_o),  VW'(c.cnt));
                            check("cmd_operands", cmd_operands_o,    c.ops);
                        end
                        hold = 1'b0;
                    end else begin
                        hold  = 1'b1;
                        h_op  = cmd_opcode_o;
                        h_cnt = cmd_count_o;
                        h_ops = cmd_operands_o;
                    end
                end else begin
                    hold = 1'b0;
                end
                if (echo_valid_o) begin
                    check("echo_ready_mirror", VW'(in_ready_o), VW'(echo_ready_i));
                    if (echo_ready_i) begin
                        if (exp_echo.size() == 0) begin
                            unexpected("echo_unexpected", VW'(echo_data_o));
                        end else begin
                            e = exp_echo.pop_front();
                            check("echo_data", VW'(echo_data_o), VW'(e));
                        end
                    end
                end
                if (err_o) begin
                    if (exp_err.size() == 0) begin
                        unexpected("err_unexpected", VW'(err_code_o));
                    end else begin
                        ec = exp_err.pop_front();
                        check("err_code", VW'(err_code_o), VW'(ec));
                    end
                end
            end
        end
    end

    initial begin : main_proc
        logic [7:0] pay[$];
        logic [7:0] op;
        logic [7:0] arith[3];
        int         kind;
        int         p;
        arith[0] = OP_ADD;
        arith[1] = OP_MUL;
        arith[2] = OP_DIV;

        // Reset state, then in_ready rises only after the first edge out of reset.
        #2;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", VW'(in_ready_o), '0);
        @(negedge clk);
        #1;
        check("ready_after_edge", VW'(in_ready_o), VW'(1'b1));
        @(negedge clk);

        // ADD with two operands, zero-wait issue.
        pay = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        send_packet(OP_ADD, 12, pay, 1'b0);
        #1;
        check("add_valid",    VW'(cmd_valid_o), VW'(1'b1));
        check("add_count",    VW'(cmd_count_o), VW'(3'd2));
        check("add_operands", cmd_operands_o, 128'h0000_0000_0000_0000_0000_0002_0000_0001);
        @(negedge clk);
        #1;
        check("add_valid_one_cycle", VW'(cmd_valid_o), '0);
        @(negedge clk);

        // ECHO under random backpressure.
        bg_rand = 1'b1;
        pay = '{8'hAA, 8'hBB, 8'hCC};
        send_packet(OP_ECHO, 7, pay, 1'b0);
        bg_rand = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("echo_all_seen", VW'(exp_echo.size()), '0);

        // Unknown opcode, then a valid packet.
        pay = {};
        model_packet(8'h5A, 0, pay);
        send_byte(8'h5A, 1'b0);
        #1;
        check("badop_err",      VW'(err_o),      VW'(1'b1));
        check("badop_err_code", VW'(err_code_o), VW'(2'd1));
        @(negedge clk);
        pay = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hF0, 8'hDE, 8'hBC, 8'h9A, 8'h05, 8'h00, 8'h00, 8'h00};
        send_packet(OP_ADD, 16, pay, 1'b1);
        @(negedge clk);

        // Bad length drains 7 bytes; the next packet parses; then a short length.
        pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        send_packet(OP_MUL, 11, pay, 1'b0);
        #1;
        check("badlen_code_held", VW'(err_code_o), VW'(2'd3));
        @(negedge clk);
        pay = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
        send_packet(OP_DIV, 12, pay, 1'b0);
        @(negedge clk);
        pay = {};
        send_packet(OP_ADD, 2, pay, 1'b0);
        #1;
        check("short_code", VW'(err_code_o), VW'(2'd2));
        @(negedge clk);

        // Command stall: five cycles held, then release.
        cmd_force = 1'b0;
        pay = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0D, 8'hF0, 8'hAD, 8'h0B};
        send_packet(OP_ADD, 12, pay, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_valid", VW'(cmd_valid_o), VW'(1'b1));
            check("stall_ready", VW'(in_ready_o),  '0);
            @(negedge clk);
        end
        cmd_force = 1'b1;
        @(negedge clk);
        #1;
        check("stall_release", VW'(cmd_valid_o), '0);
        @(negedge clk);

        // Reset in the middle of the operand phase; no stale operands afterwards.
        send_byte(OP_MUL, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'd20, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 12; i++) send_byte(8'(i + 8'h31), 1'b0);
        in_valid_i = 1'b1;
        in_data_i  = 8'h99;
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        in_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pay = '{8'h0A, 8'h00, 8'h00, 8'h00, 8'h0B, 8'h00, 8'h00, 8'h00};
        send_packet(OP_ADD, 12, pay, 1'b0);
        #1;
        check("postreset_operands", cmd_operands_o, 128'h0000_0000_0000_0000_0000_000B_0000_000A);
        @(negedge clk);

        // Randomised packet mix under random backpressure.
        bg_rand = 1'b1;
        for (int n = 0; n < 150; n++) begin
            pay  = {};
            kind = $urandom_range(0, 4);
            case (kind)
                0: begin
                    do op = 8'($urandom); while (known(op));
                    send_packet(op, 0, pay, 1'b1);
                end
                1: begin
                    op = ($urandom_range(0, 1) == 0) ? OP_ECHO : arith[$urandom_range(0, 2)];
                    send_packet(op, $urandom_range(0, 3), pay, 1'b1);
                end
                2: begin
                    p = $urandom_range(0, 8);
                    for (int i = 0; i < p; i++) pay.push_back(8'($urandom));
                    send_packet(OP_ECHO, p + 4, pay, 1'b1);
                end
                3: begin
                    p = B * $urandom_range(2, N);
                    for (int i = 0; i < p; i++) pay.push_back(8'($urandom));
                    send_packet(arith[$urandom_range(0, 2)], p + 4, pay, 1'b1);
                end
                default: begin
                    p = $urandom_range(0, 20);
                    for (int i = 0; i < p; i++) pay.push_back(8'($urandom));
                    send_packet(arith[$urandom_range(0, 2)], p + 4, pay, 1'b1);
                end
            endcase
        end
        bg_rand   = 1'b0;
        cmd_force = 1'b1;
        repeat (5) @(negedge clk);

        check("cmds_remaining",   VW'(exp_cmd.size()),  '0);
        check("echoes_remaining", VW'(exp_echo.size()), '0);
        check("errs_remaining",   VW'(exp_err.size()),  '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
